aes_cipher_core: RTL and testbench



---
 rtl/aes_cipher_core.sv | 149 ++++++++++++++
 tb/tb_aes_cipher_core.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_core.sv
// Iterative AES encryption core: one round per clock over an externally held key schedule.
// Round key r is w[128*r +: 128]; bit 0 of every vector is the MSB, byte k = bits [8k:8k+7].
module aes_cipher_core #(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [0:127]            din,
    input  logic [0:128*(Nr+1)-1]   w,
    output logic                    busy,
    output logic                    done,
    output logic [0:127]            dout
);

    // Nk only has to agree with the key-expansion stage; reject inconsistent pairs early.
    if (!((Nk == 4 && Nr == 10) || (Nk == 6 && Nr == 12) || (Nk == 8 && Nr == 14))) begin : g_bad_cfg
        $error("aes_cipher_core: unsupported Nk/Nr combination");
    end

    localparam logic [3:0] NrLast = 4'(Nr);

    // Forward S-box, byte 0x00 at bits [0:7].
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {StIdle, StRun} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [0:127] state_q, state_d;
    logic [0:127] dout_q, dout_d;
    logic         done_q, done_d;

    logic [0:127] sb, sr, mc, rk, round_out;
    logic [10:0]  rk_idx;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {b, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:31] mix_col(input logic [0:31] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[0:7];
        a1 = c[8:15];
        a2 = c[16:23];
        a3 = c[24:31];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // One full round: SubBytes, ShiftRows, MixColumns (skipped in the last round), AddRoundKey.
    always_comb begin
        sb = '0;
        sr = '0;
        mc = '0;
        for (int k = 0; k < 16; k++) begin
            sb[8*k +: 8] = sbox(state_q[8*k +: 8]);
        end
        // Row r rotates left by r columns.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sr[8*(r+4*c) +: 8] = sb[8*(r+4*((c+r)%4)) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[32*c +: 32] = mix_col(sr[32*c +: 32]);
        end
        rk_idx    = {rnd_q, 7'b0000000};
        rk        = w[rk_idx +: 128];
        round_out = ((rnd_q == NrLast) ? sr : mc) ^ rk;
    end

    // Next-state logic: load with round key 0, then one round per edge until round Nr.
    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        unique case (fsm_q)
            StIdle: begin
                if (start) begin
                    state_d = din ^ w[0:127];
                    rnd_d   = 4'd1;
                    fsm_d   = StRun;
                end
            end
            StRun: begin
                state_d = round_out;
                if (rnd_q == NrLast) begin
                    dout_d = round_out;
                    done_d = 1'b1;
                    fsm_d  = StIdle;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= StIdle;
            rnd_q   <= 4'd0;
            state_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (fsm_q == StRun);
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Directed FIPS-197 vectors for aes_cipher_core (AES-128 and AES-256 instances).
module tb_aes_cipher_core;

    localparam logic [0:127] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:255] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:127] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s128, s256;
    logic [0:127]  d128, d256;
    logic [0:1407] w128;
    logic [0:1919] w256;
    logic          busy128, done128, busy256, done256;
    logic [0:127]  dout128, dout256;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned dp128  = 0;
    int unsigned dp256  = 0;

    always #5 clk = ~clk;

    aes_cipher_core #(.Nk(4), .Nr(10)) u_dut128 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s128),
        .din   (d128),
        .w     (w128),
        .busy  (busy128),
        .done  (done128),
        .dout  (dout128)
    );

    aes_cipher_core #(.Nk(8), .Nr(14)) u_dut256 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s256),
        .din   (d256),
        .w     (w256),
        .busy  (busy256),
        .done  (done256),
        .dout  (dout256)
    );

    // Count done pulses: at each edge, done still shows the cycle that just ended.
    always @(posedge clk) begin
        if (done128) dp128++;
        if (done256) dp256++;
    end

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {b, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // Reference key expansion standing in for the upstream stage.
    function automatic logic [0:1919] expand_key(input logic [0:255] key, input int nk);
        logic [31:0]   wd [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1919] s;
        int            nw;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        s  = '0;
        for (int i = 0; i < nw; i++) begin
            if (i < nk) begin
                wd[i] = key[32*i +: 32];
            end else begin
                t = wd[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                wd[i] = wd[i-nk] ^ t;
            end
            s[32*i +: 32] = wd[i];
        end
        return s;
    endfunction

    task automatic load_key128(input logic [0:127] key);
        logic [0:1919] sched;
        sched = expand_key({key, 128'h0}, 4);
        w128  = sched[0:1407];
    endtask

    // Runs one AES-128 block from the current negedge; optional extra start pulse sampled at
    // edge E<pulse_at>. Returns at the negedge where done is seen (or after a 40-cycle bound).
    task automatic blk128(input logic [0:127] d, input int pulse_at, input logic [0:127] pd,
                          output int lat, output int bcnt, output logic bz);
        lat  = 0;
        bcnt = 0;
        s128 = 1'b1;
        d128 = d;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == pulse_at - 1) begin
                s128 = 1'b1;
                d128 = pd;
            end else begin
                s128 = 1'b0;
                d128 = {$urandom, $urandom, $urandom, $urandom};
            end
            if (done128) break;
            if (busy128) bcnt++;
        end
        bz = busy128;
    endtask

    task automatic blk256(input logic [0:127] d, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        s256 = 1'b1;
        d256 = d;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            s256 = 1'b0;
            d256 = {$urandom, $urandom, $urandom, $urandom};
            if (done256) break;
            if (busy256) bcnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s128  = 1'b0;
        s256  = 1'b0;
        d128  = '0;
        d256  = '0;
        #3;
        total++; if (busy128 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy128);
        else passed++;
        total++; if (done128 !== 1'b0) $display("FAIL reset_done: got %b want 0", done128);
        else passed++;
        total++; if (dout128 !== 128'h0) $display("FAIL reset_dout128: got %h want 0", dout128);
        else passed++;
        total++; if (dout256 !== 128'h0) $display("FAIL reset_dout256: got %h want 0", dout256);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips_b();
        int lat, bc;
        logic bz;
        logic [0:127] held;
        load_key128(KEY_B);
        blk128(PT_B, 0, '0, lat, bc, bz);
        total++; if (dout128 !== CT_B) $display("FAIL b_dout: got %h want %h", dout128, CT_B);
        else passed++;
        total++; if (lat != 11) $display("FAIL b_latency: got %0d want 11", lat);
        else passed++;
        total++; if (bc != 10) $display("FAIL b_busy_cycles: got %0d want 10", bc);
        else passed++;
        total++; if (bz !== 1'b0) $display("FAIL b_busy_at_done: got %b want 0", bz);
        else passed++;
        held = dout128;
        @(negedge clk);
        total++; if (done128 !== 1'b0) $display("FAIL b_done_pulse: got %b want 0", done128);
        else passed++;
        total++; if (dout128 !== CT_B) $display("FAIL b_dout_hold: got %h want %h", dout128, CT_B);
        else passed++;
    endtask

    task automatic test_c1();
        int lat, bc;
        logic bz;
        load_key128(KEY_C1);
        blk128(PT_C, 0, '0, lat, bc, bz);
        total++; if (dout128 !== CT_C1) $display("FAIL c1_dout: got %h want %h", dout128, CT_C1);
        else passed++;
        total++; if (lat != 11) $display("FAIL c1_latency: got %0d want 11", lat);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_c3();
        int lat, bc;
        w256 = expand_key(KEY_C3, 8);
        @(negedge clk);
        blk256(PT_C, lat, bc);
        total++; if (dout256 !== CT_C3) $display("FAIL c3_dout: got %h want %h", dout256, CT_C3);
        else passed++;
        total++; if (lat != 15) $display("FAIL c3_latency: got %0d want 15", lat);
        else passed++;
        total++; if (bc != 14) $display("FAIL c3_busy_cycles: got %0d want 14", bc);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic bz;
        int unsigned p0;
        load_key128(KEY_B);
        @(negedge clk);
        p0 = dp128;
        blk128(PT_B, 3, 128'hdeadbeef_01234567_89abcdef_cafef00d, lat, bc, bz);
        total++; if (dout128 !== CT_B) $display("FAIL b2b_first_dout: got %h want %h", dout128, CT_B);
        else passed++;
        total++; if (lat != 11) $display("FAIL b2b_first_latency: got %0d want 11", lat);
        else passed++;
        // Now in the done cycle: first result is already registered, so the schedule may
        // switch before the accepting edge of the next block.
        load_key128(KEY_C1);
        blk128(PT_C, 0, '0, lat, bc, bz);
        total++; if (dout128 !== CT_C1) $display("FAIL b2b_second_dout: got %h want %h", dout128, CT_C1);
        else passed++;
        total++; if (lat != 11) $display("FAIL b2b_second_latency: got %0d want 11", lat);
        else passed++;
        @(negedge clk);
        total++; if (dp128 - p0 != 2) $display("FAIL b2b_done_pulses: got %0d want 2", dp128 - p0);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        logic bz;
        int unsigned p0;
        load_key128(KEY_B);
        s128 = 1'b1;
        d128 = PT_B;
        @(negedge clk);
        s128 = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy128 !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy128);
        else passed++;
        total++; if (done128 !== 1'b0) $display("FAIL rmid_done: got %b want 0", done128);
        else passed++;
        total++; if (dout128 !== 128'h0) $display("FAIL rmid_dout: got %h want 0", dout128);
        else passed++;
        p0 = dp128;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        total++; if (dp128 != p0) $display("FAIL rmid_no_done: got %0d pulses want 0", dp128 - p0);
        else passed++;
        total++; if (busy128 !== 1'b0) $display("FAIL rmid_idle: got busy %b want 0", busy128);
        else passed++;
        blk128(PT_B, 0, '0, lat, bc, bz);
        total++; if (dout128 !== CT_B) $display("FAIL rmid_restart_dout: got %h want %h", dout128, CT_B);
        else passed++;
        total++; if (lat != 11) $display("FAIL rmid_restart_latency: got %0d want 11", lat);
        else passed++;
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            s128 = 1'b0;
            d128 = {$urandom, $urandom, $urandom, $urandom};
            total++; if (dout128 !== CT_B) $display("FAIL idle_dout[%0d]: got %h want %h", i, dout128, CT_B);
            else passed++;
            total++; if (done128 !== 1'b0) $display("FAIL idle_done[%0d]: got %b want 0", i, done128);
            else passed++;
        end
    endtask

    initial begin
        w128 = '0;
        w256 = '0;
        test_reset();
        test_fips_b();
        test_c1();
        test_c3();
        test_back_to_back();
        test_reset_mid();
        test_idle_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
